hall_conditioner: RTL and testbench

Upstream front end for the BLDC commutation logic in `MAIN`.
- Synchronises and deglitches the three raw Hall sensor inputs.
- Decodes them into a commutation sector (0–5) with rotation direction.
- Measures the clock-cycle period between sector edges for speed estimation.
- Flags illegal codes, skipped sectors and rotor stall, so the commutation stage only ever sees filtered, validated sector information.

---
 rtl/hall_conditioner.sv | 128 ++++++++++++
 tb/tb_hall_conditioner.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_conditioner.sv
// rtl/hall_conditioner.sv - Hall sensor synchroniser, deglitch filter, sector decoder and edge-period meter.
module hall_conditioner #(
    parameter int FILTER_CYCLES = 8,
    parameter int PERIOD_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                H1,
    input  logic                H2,
    input  logic                H3,
    input  logic                fault_clr,
    output logic [2:0]          sector,
    output logic                hall_valid,
    output logic                dir,
    output logic                edge_stb,
    output logic [PERIOD_W-1:0] period,
    output logic                period_stb,
    output logic                stall,
    output logic [1:0]          fault
);

    localparam logic [7:0]          FILT    = 8'(FILTER_CYCLES);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    logic [2:0]          r_s1, r_s2, r_cand, r_acc, r_sector;
    logic [7:0]          r_stab;
    logic [PERIOD_W-1:0] r_cnt, r_period;
    logic                r_hall_valid, r_dir, r_edge_stb, r_period_stb, r_stall;
    logic [1:0]          r_fault;

    logic [2:0] w_new_sec;
    logic       w_legal, w_accept, w_init;
    logic [3:0] w_diff, w_delta;

    always_comb begin
        w_new_sec = 3'd0;
        w_legal   = 1'b1;
        case (r_cand)
            3'b001:  w_new_sec = 3'd0;
            3'b101:  w_new_sec = 3'd1;
            3'b100:  w_new_sec = 3'd2;
            3'b110:  w_new_sec = 3'd3;
            3'b010:  w_new_sec = 3'd4;
            3'b011:  w_new_sec = 3'd5;
            default: w_legal   = 1'b0;
        endcase
    end

    // Candidate must have been stable for FILTER_CYCLES and differ from the accepted code.
    assign w_accept = (r_s2 == r_cand) && (r_stab == FILT) && (r_cand != r_acc);
    assign w_init   = !r_hall_valid || r_stall;
    assign w_diff   = {1'b0, w_new_sec} + 4'd6 - {1'b0, r_sector};
    assign w_delta  = (w_diff >= 4'd6) ? (w_diff - 4'd6) : w_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1         <= 3'b000;
            r_s2         <= 3'b000;
            r_cand       <= 3'b000;
            r_stab       <= 8'd0;
            r_acc        <= 3'b000;
            r_cnt        <= '0;
            r_sector     <= 3'd0;
            r_hall_valid <= 1'b0;
            r_dir        <= 1'b0;
            r_edge_stb   <= 1'b0;
            r_period     <= '0;
            r_period_stb <= 1'b0;
            r_stall      <= 1'b0;
            r_fault      <= 2'b00;
        end else begin
            r_s1 <= {H3, H2, H1};
            r_s2 <= r_s1;

            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_stab <= 8'd1;
            end else if (r_stab != FILT) begin
                r_stab <= r_stab + 8'd1;
            end

            r_edge_stb   <= 1'b0;
            r_period_stb <= 1'b0;
            r_fault      <= fault_clr ? 2'b00 : r_fault;

            if (w_accept && w_legal) begin
                r_cnt   <= CNT_ONE;
                r_stall <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
                if (r_cnt == CNT_MAX) r_stall <= 1'b1;
            end

            if (w_accept) begin
                r_acc <= r_cand;
                if (!w_legal) begin
                    r_fault[0]   <= 1'b1;
                    r_hall_valid <= 1'b0;
                end else begin
                    r_sector     <= w_new_sec;
                    r_hall_valid <= 1'b1;
                    r_edge_stb   <= 1'b1;
                    // Init edges (after illegal code or stall) only re-seed the period counter.
                    if (!w_init) begin
                        if (w_delta == 4'd1 || w_delta == 4'd5) begin
                            r_dir        <= (w_delta == 4'd1);
                            r_period     <= r_cnt;
                            r_period_stb <= 1'b1;
                        end else begin
                            r_fault[1] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign sector     = r_sector;
    assign hall_valid = r_hall_valid;
    assign dir        = r_dir;
    assign edge_stb   = r_edge_stb;
    assign period     = r_period;
    assign period_stb = r_period_stb;
    assign stall      = r_stall;
    assign fault      = r_fault;

endmodule

// File: tb/tb_hall_conditioner.sv
// tb/tb_hall_conditioner.sv - Self-checking bench for hall_conditioner with a segment-level reference model.
module tb_hall_conditioner;

    localparam int F    = 8;
    localparam int MAXP = 65535;

    logic clk = 1'b0;
    logic rst, H1, H2, H3, fault_clr;

    logic [2:0]  d_sector;
    logic        d_valid, d_dir, d_estb, d_pstb, d_stall;
    logic [15:0] d_period;
    logic [1:0]  d_fault;

    logic [2:0]  s_sector;
    logic        s_valid, s_dir, s_estb, s_pstb, s_stall;
    logic [7:0]  s_period;
    logic [1:0]  s_fault;

    hall_conditioner #(.FILTER_CYCLES(F), .PERIOD_W(16)) dut (
        .clk(clk), .rst(rst), .H1(H1), .H2(H2), .H3(H3), .fault_clr(fault_clr),
        .sector(d_sector), .hall_valid(d_valid), .dir(d_dir), .edge_stb(d_estb),
        .period(d_period), .period_stb(d_pstb), .stall(d_stall), .fault(d_fault)
    );

    hall_conditioner #(.FILTER_CYCLES(F), .PERIOD_W(8)) dut_s (
        .clk(clk), .rst(rst), .H1(H1), .H2(H2), .H3(H3), .fault_clr(fault_clr),
        .sector(s_sector), .hall_valid(s_valid), .dir(s_dir), .edge_stb(s_estb),
        .period(s_period), .period_stb(s_pstb), .stall(s_stall), .fault(s_fault)
    );

    always #10 clk = ~clk;

    typedef struct {
        int t;
        int sec;
        bit dir;
        bit pstb;
        int per;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   n_pstb = 0, n_estb = 0;
    bit   mon_en = 1'b0;
    int   seg_start;
    logic [2:0] cur_raw;

    logic [2:0] m_acc;
    int         m_sec, m_period, m_L;
    bit         m_valid, m_dir;
    logic [1:0] m_fault;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int sec_of(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b101:  return 1;
            3'b100:  return 2;
            3'b110:  return 3;
            3'b010:  return 4;
            3'b011:  return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input int s);
        logic [2:0] tbl [6];
        tbl = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};
        return tbl[s];
    endfunction

    // Event monitor: every accepted legal edge the model predicts must appear exactly on its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                checks++; failures++;
                $display("FAIL missed_edge t=%0d actual=no_strobe required_sector=%0d", exp_q[0].t, exp_q[0].sec);
                void'(exp_q.pop_front());
            end
            if (d_pstb === 1'b1) n_pstb++;
            if (d_estb === 1'b1) n_estb++;
            if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (d_estb !== 1'b1 || d_sector !== 3'(mon_e.sec) || d_dir !== mon_e.dir || d_pstb !== mon_e.pstb) begin
                    failures++;
                    $display("FAIL edge_event t=%0d actual estb=%b sec=%0d dir=%b pstb=%b required estb=1 sec=%0d dir=%b pstb=%b",
                             cyc, d_estb, d_sector, d_dir, d_pstb, mon_e.sec, mon_e.dir, mon_e.pstb);
                end
                if (mon_e.pstb) begin
                    checks++;
                    if (d_period !== 16'(mon_e.per)) begin
                        failures++;
                        $display("FAIL edge_period t=%0d actual=%0d required=%0d", cyc, d_period, mon_e.per);
                    end
                end
            end else begin
                checks++;
                if (d_estb !== 1'b0 || d_pstb !== 1'b0) begin
                    failures++;
                    $display("FAIL spurious_strobe t=%0d actual estb=%b pstb=%b required 0 0", cyc, d_estb, d_pstb);
                end
            end
        end
    end

    task automatic do_reset();
        int r;
        rst = 1'b1;
        r = cyc + 1;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].t >= r) void'(exp_q.pop_back());
        m_acc = 3'b000; m_sec = 0; m_valid = 1'b0; m_dir = 1'b0;
        m_fault = 2'b00; m_period = 0; m_L = r + 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic seg_drive(input logic [2:0] code, input int len);
        int t, s, d;
        {H3, H2, H1} = code;
        cur_raw = code;
        seg_start = cyc + 1;
        if (len >= F + 1 && code != m_acc) begin
            t = seg_start + F + 2;
            m_acc = code;
            if (code == 3'b000 || code == 3'b111) begin
                m_fault[0] = 1'b1;
                m_valid = 1'b0;
            end else begin
                s = sec_of(code);
                if (!m_valid || t > m_L + MAXP) begin
                    exp_q.push_back('{t, s, m_dir, 1'b0, 0});
                end else begin
                    d = (s - m_sec + 6) % 6;
                    if (d == 1 || d == 5) begin
                        m_dir = (d == 1);
                        m_period = (t - m_L > MAXP) ? MAXP : t - m_L;
                        exp_q.push_back('{t, s, m_dir, 1'b1, m_period});
                    end else begin
                        m_fault[1] = 1'b1;
                        exp_q.push_back('{t, s, m_dir, 1'b0, 0});
                    end
                end
                m_sec = s; m_valid = 1'b1; m_L = t;
            end
        end
    endtask

    task automatic seg(input logic [2:0] code, input int len);
        seg_drive(code, len);
        repeat (len) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        checks++;
        if (d_sector !== 3'd0 || d_valid !== 1'b0 || d_dir !== 1'b0 || d_period !== 16'd0) begin
            failures++;
            $display("FAIL reset_state actual sec=%0d valid=%b dir=%b per=%0d required 0 0 0 0", d_sector, d_valid, d_dir, d_period);
        end
        checks++;
        if (d_estb !== 1'b0 || d_pstb !== 1'b0 || d_stall !== 1'b0 || d_fault !== 2'b00 || s_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags actual estb=%b pstb=%b stall=%b fault=%b required 0 0 0 00", d_estb, d_pstb, d_stall, d_fault);
        end
    endtask

    task automatic test_forward();
        int p0;
        p0 = n_pstb;
        for (int i = 0; i < 13; i++) seg(code_of(i % 6), 50);
        checks++;
        if (n_pstb - p0 !== 12) begin
            failures++;
            $display("FAIL fwd_pstb_count actual=%0d required=12", n_pstb - p0);
        end
        checks++;
        if (d_sector !== 3'd0 || d_dir !== 1'b1 || d_period !== 16'd50 || d_fault !== 2'b00 || d_valid !== 1'b1) begin
            failures++;
            $display("FAIL fwd_state actual sec=%0d dir=%b per=%0d fault=%b valid=%b required 0 1 50 00 1", d_sector, d_dir, d_period, d_fault, d_valid);
        end
    endtask

    task automatic test_reverse();
        int p0;
        do_reset();
        p0 = n_pstb;
        for (int i = 0; i < 13; i++) seg(code_of(5 - (i % 6)), 50);
        checks++;
        if (n_pstb - p0 !== 12) begin
            failures++;
            $display("FAIL rev_pstb_count actual=%0d required=12", n_pstb - p0);
        end
        checks++;
        if (d_sector !== 3'd5 || d_dir !== 1'b0 || d_period !== 16'd50 || d_fault !== 2'b00) begin
            failures++;
            $display("FAIL rev_state actual sec=%0d dir=%b per=%0d fault=%b required 5 0 50 00", d_sector, d_dir, d_period, d_fault);
        end
    endtask

    task automatic test_glitch();
        int e0;
        seg(3'b001, 50); seg(3'b101, 50); seg(3'b100, 50);
        e0 = n_estb;
        seg(3'b110, 5);
        seg(3'b100, 40);
        checks++;
        if (n_estb !== e0 || d_sector !== 3'd2) begin
            failures++;
            $display("FAIL glitch_reject actual edges=%0d sec=%0d required edges=0 sec=2", n_estb - e0, d_sector);
        end
        seg(3'b110, 9);
        seg(3'b010, 50);
        checks++;
        if (n_estb - e0 !== 2 || d_sector !== 3'd4 || d_period !== 16'd9) begin
            failures++;
            $display("FAIL glitch_accept actual edges=%0d sec=%0d per=%0d required 2 4 9", n_estb - e0, d_sector, d_period);
        end
    endtask

    task automatic test_illegal_skip();
        int p0;
        seg(3'b111, 20);
        checks++;
        if (d_fault !== 2'b01 || d_valid !== 1'b0 || d_sector !== 3'd4) begin
            failures++;
            $display("FAIL illegal_code actual fault=%b valid=%b sec=%0d required 01 0 4", d_fault, d_valid, d_sector);
        end
        p0 = n_pstb;
        seg(3'b100, 50);
        checks++;
        if (d_valid !== 1'b1 || d_sector !== 3'd2 || n_pstb !== p0) begin
            failures++;
            $display("FAIL illegal_reinit actual valid=%b sec=%0d pstb=%0d required 1 2 0", d_valid, d_sector, n_pstb - p0);
        end
        seg(3'b101, 50);
        seg(3'b001, 50);
        p0 = n_pstb;
        seg(3'b100, 50);
        checks++;
        if (d_fault !== 2'b11 || d_sector !== 3'd2 || n_pstb !== p0) begin
            failures++;
            $display("FAIL skip_sector actual fault=%b sec=%0d pstb=%0d required 11 2 0", d_fault, d_sector, n_pstb - p0);
        end
        seg_drive(3'b000, 20);
        repeat (F + 2) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (d_fault !== 2'b01 || d_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_vs_set actual fault=%b valid=%b required 01 0", d_fault, d_valid);
        end
        repeat (20 - F - 3) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        m_fault = 2'b00;
        checks++;
        if (d_fault !== 2'b00) begin
            failures++;
            $display("FAIL fault_clr actual=%b required=00", d_fault);
        end
    endtask

    task automatic test_stall();
        int l;
        do_reset();
        seg(3'b001, 60);
        seg_drive(3'b101, 400);
        l = seg_start + F + 2;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cyc == l + 254) begin
                checks++;
                if (s_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_early actual=%b required=0", s_stall);
                end
            end
            if (cyc == l + 255) begin
                checks++;
                if (s_stall !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_rise actual=%b required=1", s_stall);
                end
            end
        end
        seg_drive(3'b100, 50);
        repeat (F + 3) @(negedge clk);
        checks++;
        if (s_estb !== 1'b1 || s_pstb !== 1'b0 || s_stall !== 1'b0 || s_sector !== 3'd2) begin
            failures++;
            $display("FAIL stall_exit actual estb=%b pstb=%b stall=%b sec=%0d required 1 0 0 2", s_estb, s_pstb, s_stall, s_sector);
        end
        repeat (50 - F - 3) @(negedge clk);
        seg_drive(3'b110, 50);
        repeat (F + 3) @(negedge clk);
        checks++;
        if (s_pstb !== 1'b1 || s_period !== 8'd50 || s_dir !== 1'b1) begin
            failures++;
            $display("FAIL stall_next_period actual pstb=%b per=%0d dir=%b required 1 50 1", s_pstb, s_period, s_dir);
        end
        repeat (50 - F - 3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int p0;
        seg(3'b010, 50);
        seg(3'b011, 20);
        do_reset();
        checks++;
        if (d_sector !== 3'd0 || d_valid !== 1'b0 || d_dir !== 1'b0 || d_period !== 16'd0 ||
            d_estb !== 1'b0 || d_pstb !== 1'b0 || d_stall !== 1'b0 || d_fault !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset actual sec=%0d valid=%b dir=%b per=%0d fault=%b required all zero", d_sector, d_valid, d_dir, d_period, d_fault);
        end
        p0 = n_pstb;
        seg(3'b011, 50);
        checks++;
        if (d_sector !== 3'd5 || d_valid !== 1'b1 || d_dir !== 1'b0 || n_pstb !== p0) begin
            failures++;
            $display("FAIL mid_reset_init actual sec=%0d valid=%b dir=%b pstb=%0d required 5 1 0 0", d_sector, d_valid, d_dir, n_pstb - p0);
        end
        seg(3'b001, 50);
        checks++;
        if (d_dir !== 1'b1 || d_period !== 16'd50 || n_pstb - p0 !== 1) begin
            failures++;
            $display("FAIL mid_reset_next actual dir=%b per=%0d pstb=%0d required 1 50 1", d_dir, d_period, n_pstb - p0);
        end
    endtask

    task automatic test_random();
        logic [2:0] c;
        int r, len, s;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            s = sec_of(cur_raw);
            if (s >= 0 && r < 4)      c = code_of((s + 1) % 6);
            else if (s >= 0 && r < 7) c = code_of((s + 5) % 6);
            else begin
                c = 3'($urandom_range(0, 7));
                while (c == cur_raw) c = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, F);
            else                           len = $urandom_range(F + 1, 70);
            seg(c, len);
        end
        c = 3'b001;
        if (cur_raw == 3'b001) c = 3'b101;
        seg(c, 40);
        checks++;
        if (d_sector !== 3'(m_sec) || d_valid !== m_valid || d_dir !== m_dir || d_fault !== m_fault) begin
            failures++;
            $display("FAIL random_state actual sec=%0d valid=%b dir=%b fault=%b required %0d %b %b %b",
                     d_sector, d_valid, d_dir, d_fault, m_sec, m_valid, m_dir, m_fault);
        end
        checks++;
        if (d_period !== 16'(m_period) || d_stall !== 1'b0) begin
            failures++;
            $display("FAIL random_period actual per=%0d stall=%b required %0d 0", d_period, d_stall, m_period);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fault_clr = 1'b0;
        {H3, H2, H1} = 3'b000;
        cur_raw = 3'b000;
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal_skip();
        test_stall();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_edges actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
